main_data_sequencer: RTL and testbench

Scheduler for the bit-reservoir FIFO read port in the MP3 Layer III parse chain. After side info for a frame is latched, it discards stale reservoir bits ahead of `main_data_begin`. It then grants the FIFO, one granule/channel at a time, first to the scalefactor parser and then to the Huffman decoder. It drives the single `fifo_rd_en` plus the phase and `gr`/`ch` steering flags used to gate each consumer's `axiiv`.

---
 rtl/main_data_sequencer_if.sv | 43 ++++
 rtl/main_data_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_main_data_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_data_sequencer_if.sv
// Side-info, FIFO read and phase-steering signals of main_data_sequencer.
// MDS_MONO_EN adds the mono side-info bit.
interface main_data_sequencer_if #(
    parameter int unsigned FIFO_CW = 16
);
    logic                   si_valid;
    logic [8:0]             main_data_begin;
    logic [1:0][1:0][11:0]  part2_3_length;
    logic [FIFO_CW-1:0]     fifo_count;
    logic                   fifo_dout_v;
    logic                   sf_done;
`ifdef MDS_MONO_EN
    logic                   mono;
`endif
    logic                   fifo_rd_en;
    logic                   res_discard_flag;
    logic                   sf_parser_flag;
    logic                   hf_decoder_flag;
    logic                   gr;
    logic                   ch;
    logic                   frame_done;
    logic                   underflow_err;
    logic                   sf_overrun_err;
    logic                   si_drop;

    modport master (
        output si_valid, main_data_begin, part2_3_length, fifo_count, fifo_dout_v, sf_done,
`ifdef MDS_MONO_EN
        output mono,
`endif
        input  fifo_rd_en, res_discard_flag, sf_parser_flag, hf_decoder_flag, gr, ch,
        input  frame_done, underflow_err, sf_overrun_err, si_drop
    );

    modport slave (
        input  si_valid, main_data_begin, part2_3_length, fifo_count, fifo_dout_v, sf_done,
`ifdef MDS_MONO_EN
        input  mono,
`endif
        output fifo_rd_en, res_discard_flag, sf_parser_flag, hf_decoder_flag, gr, ch,
        output frame_done, underflow_err, sf_overrun_err, si_drop
    );
endinterface

// File: rtl/main_data_sequencer.sv
// Bit-reservoir FIFO read scheduler: discard, then scalefactor and Huffman phases per gr/ch.
// MDS_MONO_EN adds the mono input; when latched, channel 1 is skipped.
module main_data_sequencer #(
    parameter int unsigned FIFO_CW = 16,
    parameter int unsigned SF_MAX  = 255
) (
    input logic                  clk,
    input logic                  rst,
    main_data_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StDiscard, StWaitBits, StSfReq, StSfWait, StHf, StDrain, StNext
    } state_e;

    localparam logic [FIFO_CW-1:0] CntOne = FIFO_CW'(1);

    state_e                state_q, state_d;
    logic [1:0][1:0][11:0] len_q, len_d;
    logic [FIFO_CW-1:0]    disc_left_q, disc_left_d;
    logic [11:0]           used_q, used_d;
    logic [11:0]           hf_left_q, hf_left_d;
    logic                  drain_to_next_q, drain_to_next_d;
    logic                  gr_q, gr_d, ch_q, ch_d;
    logic                  rd_en_q, rd_en_d;
    logic                  disc_flag_q, disc_flag_d;
    logic                  sf_flag_q, sf_flag_d;
    logic                  hf_flag_q, hf_flag_d;
    logic                  frame_done_q, frame_done_d;
    logic                  underflow_q, underflow_d;
    logic                  overrun_q, overrun_d;
    logic                  si_drop_q, si_drop_d;
`ifdef MDS_MONO_EN
    logic                  mono_q, mono_d;
`endif

    logic [11:0]        mdb_bits;
    logic [11:0]        cur_len;
    logic [11:0]        used_inc;
    logic [11:0]        hf_rem;
    logic [FIFO_CW-1:0] disc;
    logic               last_slot;
    logic               accept;

    assign mdb_bits = {bus.main_data_begin, 3'b000};
    assign disc     = bus.fifo_count - FIFO_CW'(mdb_bits);
    assign cur_len  = len_q[gr_q][ch_q];
    assign used_inc = used_q + 12'd1;
    assign hf_rem   = cur_len - used_inc;
    // The frame_done cycle is still treated as busy for incoming side info.
    assign accept   = (state_q == StIdle) && !frame_done_q;
`ifdef MDS_MONO_EN
    assign last_slot = gr_q && (ch_q || mono_q);
`else
    assign last_slot = gr_q && ch_q;
`endif

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        disc_left_d     = disc_left_q;
        used_d          = used_q;
        hf_left_d       = hf_left_q;
        drain_to_next_d = drain_to_next_q;
        gr_d            = gr_q;
        ch_d            = ch_q;
        rd_en_d         = 1'b0;
        disc_flag_d     = 1'b0;
        sf_flag_d       = 1'b0;
        hf_flag_d       = 1'b0;
        frame_done_d    = 1'b0;
        underflow_d     = 1'b0;
        overrun_d       = 1'b0;
        si_drop_d       = bus.si_valid && !accept;
`ifdef MDS_MONO_EN
        mono_d          = mono_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.si_valid && accept) begin
                    len_d = bus.part2_3_length;
`ifdef MDS_MONO_EN
                    mono_d = bus.mono;
`endif
                    if (32'(mdb_bits) > 32'(bus.fifo_count)) begin
                        underflow_d = 1'b1;
                    end else if (disc == '0) begin
                        state_d = StWaitBits;
                    end else begin
                        state_d     = StDiscard;
                        rd_en_d     = 1'b1;
                        disc_flag_d = 1'b1;
                        disc_left_d = disc - CntOne;
                    end
                end
            end
            StDiscard: begin
                disc_flag_d = 1'b1;
                if (disc_left_q != '0) begin
                    rd_en_d     = 1'b1;
                    disc_left_d = disc_left_q - CntOne;
                end else begin
                    state_d         = StDrain;
                    drain_to_next_d = 1'b0;
                end
            end
            StWaitBits: begin
                used_d = '0;
                if (cur_len == '0) begin
                    state_d = StNext;
                end else if (32'(bus.fifo_count) >= 32'(cur_len)) begin
                    state_d   = StSfReq;
                    rd_en_d   = 1'b1;
                    sf_flag_d = 1'b1;
                end
            end
            StSfReq: begin
                sf_flag_d = 1'b1;
                state_d   = StSfWait;
            end
            StSfWait: begin
                sf_flag_d = 1'b1;
                if (bus.fifo_dout_v) begin
                    used_d = used_inc;
                    if (bus.sf_done) begin
                        sf_flag_d = 1'b0;
                        if (hf_rem == '0) begin
                            state_d = StNext;
                        end else begin
                            state_d   = StHf;
                            rd_en_d   = 1'b1;
                            hf_flag_d = 1'b1;
                            hf_left_d = hf_rem - 12'd1;
                        end
                    end else if (used_inc == 12'(SF_MAX) || used_inc == cur_len) begin
                        sf_flag_d = 1'b0;
                        overrun_d = 1'b1;
                        state_d   = StNext;
                    end else begin
                        state_d = StSfReq;
                        rd_en_d = 1'b1;
                    end
                end
            end
            StHf: begin
                hf_flag_d = 1'b1;
                if (hf_left_q != '0) begin
                    rd_en_d   = 1'b1;
                    hf_left_d = hf_left_q - 12'd1;
                end else begin
                    state_d         = StDrain;
                    drain_to_next_d = 1'b1;
                end
            end
            // Flags drop here; the last fifo_dout_v lands in this cycle.
            StDrain: begin
                state_d = drain_to_next_q ? StNext : StWaitBits;
            end
            StNext: begin
                if (last_slot) begin
                    frame_done_d = 1'b1;
                    gr_d         = 1'b0;
                    ch_d         = 1'b0;
                    state_d      = StIdle;
                end
`ifdef MDS_MONO_EN
                else if (mono_q) begin
                    gr_d    = 1'b1;
                    state_d = StWaitBits;
                end
`endif
                else if (ch_q) begin
                    gr_d    = 1'b1;
                    ch_d    = 1'b0;
                    state_d = StWaitBits;
                end else begin
                    ch_d    = 1'b1;
                    state_d = StWaitBits;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            len_q           <= '0;
            disc_left_q     <= '0;
            used_q          <= '0;
            hf_left_q       <= '0;
            drain_to_next_q <= 1'b0;
            gr_q            <= 1'b0;
            ch_q            <= 1'b0;
            rd_en_q         <= 1'b0;
            disc_flag_q     <= 1'b0;
            sf_flag_q       <= 1'b0;
            hf_flag_q       <= 1'b0;
            frame_done_q    <= 1'b0;
            underflow_q     <= 1'b0;
            overrun_q       <= 1'b0;
            si_drop_q       <= 1'b0;
`ifdef MDS_MONO_EN
            mono_q          <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            disc_left_q     <= disc_left_d;
            used_q          <= used_d;
            hf_left_q       <= hf_left_d;
            drain_to_next_q <= drain_to_next_d;
            gr_q            <= gr_d;
            ch_q            <= ch_d;
            rd_en_q         <= rd_en_d;
            disc_flag_q     <= disc_flag_d;
            sf_flag_q       <= sf_flag_d;
            hf_flag_q       <= hf_flag_d;
            frame_done_q    <= frame_done_d;
            underflow_q     <= underflow_d;
            overrun_q       <= overrun_d;
            si_drop_q       <= si_drop_d;
`ifdef MDS_MONO_EN
            mono_q          <= mono_d;
`endif
        end
    end

    assign bus.fifo_rd_en       = rd_en_q;
    assign bus.res_discard_flag = disc_flag_q;
    assign bus.sf_parser_flag   = sf_flag_q;
    assign bus.hf_decoder_flag  = hf_flag_q;
    assign bus.gr               = gr_q;
    assign bus.ch               = ch_q;
    assign bus.frame_done       = frame_done_q;
    assign bus.underflow_err    = underflow_q;
    assign bus.sf_overrun_err   = overrun_q;
    assign bus.si_drop          = si_drop_q;
endmodule

// File: tb/tb_main_data_sequencer.sv
// Scoreboard bench for main_data_sequencer: phase/pulse records are queued by the stimulus
// and compared by an independent monitor. MDS_MONO_EN also exercises the mono build.
`timescale 1ns/1ps
module tb_main_data_sequencer;
    localparam int unsigned FIFO_CW = 16;

    typedef enum logic [3:0] {KDisc, KSf, KHf, KFrame, KUnder, KOver, KDrop} kind_e;
    typedef struct packed {
        kind_e       kind;
        logic        gr;
        logic        ch;
        logic [15:0] cnt;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   total_reads = 0;
    int   sf_target = 0;
    bit   onehot_bad = 1'b0;
    bit   stray_rd = 1'b0;
    rec_t exp_q[$];

    main_data_sequencer_if #(.FIFO_CW(FIFO_CW)) bus ();

    main_data_sequencer #(.FIFO_CW(FIFO_CW), .SF_MAX(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input kind_e k, input logic g, input logic c, input int n);
        rec_t r;
        r.kind = k;
        r.gr   = g;
        r.ch   = c;
        r.cnt  = 16'(n);
        return r;
    endfunction

    function automatic int outs_word();
        return int'({bus.fifo_rd_en, bus.res_discard_flag, bus.sf_parser_flag,
                     bus.hf_decoder_flag, bus.gr, bus.ch, bus.frame_done,
                     bus.underflow_err, bus.sf_overrun_err, bus.si_drop});
    endfunction

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic observe(input rec_t got);
        rec_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got kind=%0d gr=%0d ch=%0d cnt=%0d want none",
                     got.kind, got.gr, got.ch, got.cnt);
        end else begin
            e = exp_q.pop_front();
            if (got != e) begin
                failures++;
                $display("FAIL event got kind=%0d gr=%0d ch=%0d cnt=%0d want kind=%0d gr=%0d ch=%0d cnt=%0d",
                         got.kind, got.gr, got.ch, got.cnt, e.kind, e.gr, e.ch, e.cnt);
            end
        end
    endtask

    task automatic push(input kind_e k, input logic g, input logic c, input int n);
        exp_q.push_back(mk(k, g, c, n));
    endtask

    task automatic push_slot(input logic g, input logic c, input int sfn, input int hfn);
        push(KSf, g, c, sfn);
        push(KHf, g, c, hfn);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int l00, input int l01, input int l10, input int l11);
        bus.part2_3_length[0][0] = 12'(l00);
        bus.part2_3_length[0][1] = 12'(l01);
        bus.part2_3_length[1][0] = 12'(l10);
        bus.part2_3_length[1][1] = 12'(l11);
    endtask

    task automatic pulse_si(input int mdb, input int fc);
        bus.main_data_begin = 9'(mdb);
        bus.fifo_count      = 16'(fc);
        bus.si_valid        = 1'b1;
        tick();
        bus.si_valid        = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int limit);
        int n = 0;
        while (!bus.frame_done && n < limit) begin
            tick();
            n++;
        end
        check_val(name, int'(bus.frame_done), 1);
        tick();
    endtask

    task automatic wait_hf(input logic g, input logic c, input string name);
        int n = 0;
        while (!(bus.hf_decoder_flag && bus.gr == g && bus.ch == c) && n < 1000) begin
            tick();
            n++;
        end
        check_val(name, int'(bus.hf_decoder_flag && bus.gr == g && bus.ch == c), 1);
    endtask

    // Bit FIFO: each read returns a valid bit one cycle later; sf_done on the chosen SF bit.
    initial begin : fifo_model
        logic pend;
        logic pend_sf;
        int   sfcnt;
        pend = 1'b0;
        pend_sf = 1'b0;
        sfcnt = 0;
        bus.fifo_dout_v = 1'b0;
        bus.sf_done = 1'b0;
        forever begin
            @(negedge clk);
            pend    = bus.fifo_rd_en;
            pend_sf = bus.fifo_rd_en && bus.sf_parser_flag;
            if (!bus.sf_parser_flag) sfcnt = 0;
            @(posedge clk);
            #1;
            if (pend_sf) sfcnt++;
            bus.fifo_dout_v = pend;
            bus.sf_done     = pend_sf && (sfcnt == sf_target);
        end
    end

    initial begin : monitor
        logic pd, ps, ph, pg, pc;
        int   nd, ns, nh;
        pd = 0; ps = 0; ph = 0; pg = 0; pc = 0; nd = 0; ns = 0; nh = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pd = 0; ps = 0; ph = 0; nd = 0; ns = 0; nh = 0;
            end else begin
                if (int'(bus.res_discard_flag) + int'(bus.sf_parser_flag) +
                    int'(bus.hf_decoder_flag) > 1) onehot_bad = 1'b1;
                if (bus.fifo_rd_en && !(bus.res_discard_flag || bus.sf_parser_flag ||
                                        bus.hf_decoder_flag)) stray_rd = 1'b1;
                if (bus.fifo_rd_en) total_reads++;
                if (pd && !bus.res_discard_flag) begin observe(mk(KDisc, pg, pc, nd)); nd = 0; end
                if (ps && !bus.sf_parser_flag) begin observe(mk(KSf, pg, pc, ns)); ns = 0; end
                if (ph && !bus.hf_decoder_flag) begin observe(mk(KHf, pg, pc, nh)); nh = 0; end
                if (bus.res_discard_flag || bus.sf_parser_flag || bus.hf_decoder_flag) begin
                    pg = bus.gr;
                    pc = bus.ch;
                end
                if (bus.fifo_rd_en && bus.res_discard_flag) nd++;
                if (bus.fifo_rd_en && bus.sf_parser_flag) ns++;
                if (bus.fifo_rd_en && bus.hf_decoder_flag) nh++;
                pd = bus.res_discard_flag;
                ps = bus.sf_parser_flag;
                ph = bus.hf_decoder_flag;
                if (bus.underflow_err) observe(mk(KUnder, bus.gr, bus.ch, 0));
                if (bus.sf_overrun_err) observe(mk(KOver, bus.gr, bus.ch, 0));
                if (bus.si_drop) observe(mk(KDrop, bus.gr, bus.ch, 0));
                if (bus.frame_done) observe(mk(KFrame, bus.gr, bus.ch, 0));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        bus.si_valid = 1'b0;
        bus.main_data_begin = '0;
        bus.part2_3_length = '0;
        bus.fifo_count = '0;
`ifdef MDS_MONO_EN
        bus.mono = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", outs_word(), 0);
        rst = 1'b1;
        tick();

        // Discard 100-40=60 bits, hold on a short reservoir, then a full 40-bit/4-slot frame.
        set_len(40, 40, 40, 40);
        sf_target = 10;
        push(KDisc, 0, 0, 60);
        pulse_si(5, 100);
        check_val("first_discard_read", int'(bus.fifo_rd_en && bus.res_discard_flag), 1);
        bus.fifo_count = 16'd20;
        repeat (100) tick();
        check_val("discard_reads", total_reads, 60);
        check_val("hold_wait_bits", int'(bus.fifo_rd_en), 0);
        push_slot(0, 0, 10, 30);
        push_slot(0, 1, 10, 30);
        push_slot(1, 0, 10, 30);
        push_slot(1, 1, 10, 30);
        push(KFrame, 0, 0, 0);
        bus.fifo_count = 16'd500;
        wait_frame("frame1_done", 2000);
        check_val("frame1_reads", total_reads, 220);

        // Underflow: 32 bits requested, 16 held.
        push(KUnder, 0, 0, 0);
        base = total_reads;
        pulse_si(4, 16);
        check_val("underflow_pulse", int'(bus.underflow_err), 1);
        repeat (10) tick();
        check_val("underflow_no_reads", total_reads - base, 0);
        check_val("underflow_idle_outputs", outs_word(), 0);

        // SF overrun on 8-bit slots; empty (1,1) slot is skipped. Exact-fit reservoir.
        set_len(8, 8, 8, 0);
        sf_target = 0;
        push(KSf, 0, 0, 8); push(KOver, 0, 0, 0);
        push(KSf, 0, 1, 8); push(KOver, 0, 1, 0);
        push(KSf, 1, 0, 8); push(KOver, 1, 0, 0);
        push(KFrame, 0, 0, 0);
        base = total_reads;
        pulse_si(2, 16);
        wait_frame("overrun_frame_done", 1000);
        check_val("overrun_reads", total_reads - base, 24);

        // Busy si during HF, then reset mid-HF.
        set_len(40, 40, 40, 40);
        sf_target = 10;
        push(KSf, 0, 0, 10);
        pulse_si(5, 40);
        wait_hf(0, 0, "reach_hf_00");
        push(KDrop, 0, 0, 0);
        push(KHf, 0, 0, 30);
        push(KSf, 0, 1, 10);
        bus.main_data_begin = 9'd0;
        bus.fifo_count = 16'd999;
        bus.si_valid = 1'b1;
        tick();
        bus.si_valid = 1'b0;
        check_val("busy_si_drop", int'(bus.si_drop), 1);
        wait_hf(0, 1, "reach_hf_01");
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        check_val("async_reset_outputs", outs_word(), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) tick();
        check_val("post_reset_outputs", outs_word(), 0);

        // Fresh frame after reset; si coinciding with frame_done is dropped.
        set_len(6, 6, 6, 6);
        sf_target = 2;
        push_slot(0, 0, 2, 4);
        push_slot(0, 1, 2, 4);
        push_slot(1, 0, 2, 4);
        push_slot(1, 1, 2, 4);
        push(KFrame, 0, 0, 0);
        push(KDrop, 0, 0, 0);
        base = total_reads;
        pulse_si(5, 40);
        wait_hf(1, 1, "reach_hf_11");
        begin
            int n = 0;
            while (bus.hf_decoder_flag && n < 100) begin
                tick();
                n++;
            end
        end
        tick();
        check_val("frame_done_cycle", int'(bus.frame_done), 1);
        bus.si_valid = 1'b1;
        tick();
        bus.si_valid = 1'b0;
        check_val("frame_done_si_drop", int'(bus.si_drop), 1);
        repeat (10) tick();
        check_val("restart_reads", total_reads - base, 24);

`ifdef MDS_MONO_EN
        bus.mono = 1'b1;
        set_len(6, 6, 6, 6);
        sf_target = 2;
        push_slot(0, 0, 2, 4);
        push_slot(1, 0, 2, 4);
        push(KFrame, 0, 0, 0);
        base = total_reads;
        pulse_si(5, 40);
        bus.mono = 1'b0;
        wait_frame("mono_frame_done", 500);
        check_val("mono_reads", total_reads - base, 12);
`endif

        repeat (5) tick();
        check_val("queue_drained", exp_q.size(), 0);
        check_val("one_phase_flag", int'(onehot_bad), 0);
        check_val("reads_inside_phase", int'(stray_rd), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
